// File: rtl/enemy_fire_scheduler.sv
// Enemy bullet scheduler: round-robin grants from four ships into two shared
// bullet slots, with per-ship cooldowns and tick-driven bullet motion.
module enemy_fire_scheduler #(
  parameter logic [7:0] Y_START  = 8'd0,
  parameter logic [7:0] Y_LIMIT  = 8'd119,
  parameter logic [7:0] STEP     = 8'd1,
  parameter logic [3:0] COOLDOWN = 4'd8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic [3:0]  fire_req,
  input  logic [31:0] ship_x,
  output logic [3:0]  fire_grant,
  output logic [15:0] bullet_x,
  output logic [15:0] bullet_y,
  output logic [1:0]  bullet_active
);

  logic [7:0] slot_x [2];
  logic [7:0] slot_y [2];
  logic [1:0] active;
  logic [3:0] cooldown [4];
  logic [1:0] rr;

  logic [3:0] eligible;
  logic       grant_hit;
  logic [1:0] grant_idx;
  logic [1:0] cand;
  logic       have_slot;
  logic       slot_sel;
  logic       do_grant;
  logic [8:0] y_sum [2];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      eligible[i] = fire_req[i] && (cooldown[i] == 4'd0);
    end
  end

  // Round-robin search starting at rr; first eligible index wins.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = 2'd0;
    cand      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = rr + 2'(k);
      if (!grant_hit && eligible[cand]) begin
        grant_hit = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Freedom is judged on slot state at the start of the cycle, so a slot
  // retiring on this tick cannot be reused until the next cycle.
  assign have_slot = ~(active[0] & active[1]);
  assign slot_sel  = active[0];
  assign do_grant  = grant_hit && have_slot;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      y_sum[s] = {1'b0, slot_y[s]} + {1'b0, STEP};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fire_grant <= 4'd0;
      rr         <= 2'd0;
      active     <= 2'd0;
      for (int i = 0; i < 4; i++) cooldown[i] <= 4'd0;
      for (int s = 0; s < 2; s++) begin
        slot_x[s] <= 8'd0;
        slot_y[s] <= 8'd0;
      end
    end else begin
      fire_grant <= 4'd0;
      if (do_grant) begin
        fire_grant <= 4'b0001 << grant_idx;
        rr         <= grant_idx + 2'd1;
      end
      for (int i = 0; i < 4; i++) begin
        if (do_grant && (grant_idx == 2'(i)))
          cooldown[i] <= COOLDOWN;
        else if (tick && (cooldown[i] != 4'd0))
          cooldown[i] <= cooldown[i] - 4'd1;
      end
      // A freshly launched bullet takes the grant branch, so it skips this tick.
      for (int s = 0; s < 2; s++) begin
        if (do_grant && (slot_sel == 1'(s))) begin
          slot_x[s] <= ship_x[{grant_idx, 3'b000} +: 8];
          slot_y[s] <= Y_START;
          active[s] <= 1'b1;
        end else if (tick && active[s]) begin
          if (y_sum[s] > {1'b0, Y_LIMIT}) begin
            slot_x[s] <= 8'd0;
            slot_y[s] <= 8'd0;
            active[s] <= 1'b0;
          end else begin
            slot_y[s] <= y_sum[s][7:0];
          end
        end
      end
    end
  end

  assign bullet_x      = {slot_x[1], slot_x[0]};
  assign bullet_y      = {slot_y[1], slot_y[0]};
  assign bullet_active = active;

endmodule
